// File: rtl/kbd_pkg.sv
// Shared scancode constants, decode-state encoding and parity helper for the
// PS/2 keyboard front end.
package kbd_pkg;

   localparam logic [7:0] SC_BREAK  = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_ENTER  = 8'h5A;

   localparam logic [7:0] ASCII_NONE = 8'h00;
   localparam logic [7:0] ASCII_LF   = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BRK,
      ST_EXT,
      ST_EXT_BRK
   } dec_state_t;

   // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/kbd_fifo_if.sv
// CPU-side read port of the keyboard FIFO: pop/clear strobes in, head and status out.
interface kbd_fifo_if #(
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          rd_en;
   logic          clr_err;
   logic [7:0]    ascii_key;
   logic          empty;
   logic [CW-1:0] count;
   logic          overflow;
   logic          frame_err;

   modport master (
      output rd_en, clr_err,
      input  ascii_key, empty, count, overflow, frame_err
   );

   modport slave (
      input  rd_en, clr_err,
      output ascii_key, empty, count, overflow, frame_err
   );

endinterface

// File: rtl/scancode_to_ascii.sv
// Combinational set-2 scancode to ASCII table (US layout); unmapped codes give 8'h00.
module scancode_to_ascii
   import kbd_pkg::*;
(
   input  logic [7:0] scancode,
   input  logic       shift,
   input  logic       caps,
   output logic [7:0] ascii
);

   logic [7:0] base;
   logic [7:0] alt;
   logic       letter;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      base   = ASCII_NONE;
      alt    = ASCII_NONE;
      letter = 1'b0;
      case (scancode)
         8'h1C: {letter, base} = {1'b1, "a"};
         8'h32: {letter, base} = {1'b1, "b"};
         8'h21: {letter, base} = {1'b1, "c"};
         8'h23: {letter, base} = {1'b1, "d"};
         8'h24: {letter, base} = {1'b1, "e"};
         8'h2B: {letter, base} = {1'b1, "f"};
         8'h34: {letter, base} = {1'b1, "g"};
         8'h33: {letter, base} = {1'b1, "h"};
         8'h43: {letter, base} = {1'b1, "i"};
         8'h3B: {letter, base} = {1'b1, "j"};
         8'h42: {letter, base} = {1'b1, "k"};
         8'h4B: {letter, base} = {1'b1, "l"};
         8'h3A: {letter, base} = {1'b1, "m"};
         8'h31: {letter, base} = {1'b1, "n"};
         8'h44: {letter, base} = {1'b1, "o"};
         8'h4D: {letter, base} = {1'b1, "p"};
         8'h15: {letter, base} = {1'b1, "q"};
         8'h2D: {letter, base} = {1'b1, "r"};
         8'h1B: {letter, base} = {1'b1, "s"};
         8'h2C: {letter, base} = {1'b1, "t"};
         8'h3C: {letter, base} = {1'b1, "u"};
         8'h2A: {letter, base} = {1'b1, "v"};
         8'h1D: {letter, base} = {1'b1, "w"};
         8'h22: {letter, base} = {1'b1, "x"};
         8'h35: {letter, base} = {1'b1, "y"};
         8'h1A: {letter, base} = {1'b1, "z"};
         // Digits and punctuation: {unshifted, shifted} glyph pairs.
         8'h16: {base, alt} = "1!";
         8'h1E: {base, alt} = "2@";
         8'h26: {base, alt} = "3#";
         8'h25: {base, alt} = "4$";
         8'h2E: {base, alt} = "5%";
         8'h36: {base, alt} = "6^";
         8'h3D: {base, alt} = "7&";
         8'h3E: {base, alt} = "8*";
         8'h46: {base, alt} = "9(";
         8'h45: {base, alt} = "0)";
         8'h0E: {base, alt} = "`~";
         8'h4E: {base, alt} = "-_";
         8'h55: {base, alt} = "=+";
         8'h54: {base, alt} = "[{";
         8'h5B: {base, alt} = "]}";
         8'h5D: {base, alt} = {8'h5C, 8'h7C};
         8'h4C: {base, alt} = ";:";
         8'h52: {base, alt} = {8'h27, 8'h22};
         8'h41: {base, alt} = ",<";
         8'h49: {base, alt} = ".>";
         8'h4A: {base, alt} = "/?";
         SC_ENTER: {base, alt} = {ASCII_LF, ASCII_LF};
         8'h66:    {base, alt} = {8'h08, 8'h08};
         8'h29:    {base, alt} = {8'h20, 8'h20};
         8'h76:    {base, alt} = {8'h1B, 8'h1B};
         default: ;
      endcase

      if (letter) begin
         ascii = (shift ^ caps) ? (base - 8'h20) : base;
      end else begin
         ascii = shift ? alt : base;
      end
   end

endmodule

// File: rtl/kbd_fifo.sv
// PS/2 keyboard receiver, make/break decoder and ASCII character FIFO behind the
// memory-mapped KBD_ASCII read port.
module kbd_fifo
   import kbd_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 5000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   kbd_fifo_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   // ---------------- synchroniser ----------------
   logic [2:0] clk_sync;
   logic [2:0] data_sync;
   logic       fall;

   // NOTE: clocked state always uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         clk_sync  <= '0;
         data_sync <= '0;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk};
         data_sync <= {data_sync[1:0], ps2_data};
      end
   end

   assign fall = (clk_sync[2:1] == 2'b10);

   // ---------------- frame receiver ----------------
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;
   logic [TW-1:0] idle_cnt;
   logic [10:0]   frame;
   logic          frame_done;
   logic          frame_ok;
   logic          frame_bad;
   logic          byte_valid;
   logic [7:0]    rx_byte;

   // frame[0]=start, frame[8:1]=data LSB first, frame[9]=parity, frame[10]=stop
   assign frame      = {data_sync[2], shreg};
   assign frame_done = fall && (bit_cnt == 4'd10);
   assign frame_ok   = !frame[0] && frame[10] && odd_parity_ok(frame[8:1], frame[9]);
   assign frame_bad  = frame_done && !frame_ok;

   always_ff @(posedge clock) begin
      if (!reset) begin
         bit_cnt    <= '0;
         shreg      <= '0;
         idle_cnt   <= '0;
         byte_valid <= 1'b0;
         rx_byte    <= '0;
      end else begin
         byte_valid <= frame_done && frame_ok;
         if (fall) begin
            idle_cnt <= '0;
            shreg    <= {data_sync[2], shreg[9:1]};
            bit_cnt  <= frame_done ? 4'd0 : bit_cnt + 4'd1;
            if (frame_done) rx_byte <= frame[8:1];
         end else begin
            // A stalled partial frame is abandoned silently so the next start bit realigns.
            if (idle_cnt != TW'(TIMEOUT)) idle_cnt <= idle_cnt + TW'(1);
            else                          bit_cnt  <= '0;
         end
      end
   end

   // ---------------- decode FSM ----------------
   dec_state_t state, state_next;
   logic       shift_l, shift_r, caps;
   logic       shift_l_next, shift_r_next, caps_next;
   logic       push_next;
   logic [7:0] push_char_next;
   logic       push_req;
   logic [7:0] push_char;
   logic [7:0] lookup;

   scancode_to_ascii u_xlat (
      .scancode (rx_byte),
      .shift    (shift_l | shift_r),
      .caps     (caps),
      .ascii    (lookup)
   );

   always_ff @(posedge clock) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (byte_valid) begin
         case (state)
            ST_IDLE: begin
               if      (rx_byte == SC_BREAK) state_next = ST_BRK;
               else if (rx_byte == SC_EXT)   state_next = ST_EXT;
            end
            ST_EXT:  state_next = (rx_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      shift_l_next   = shift_l;
      shift_r_next   = shift_r;
      caps_next      = caps;
      push_next      = 1'b0;
      push_char_next = ASCII_NONE;
      if (byte_valid) begin
         case (state)
            ST_IDLE: begin
               case (rx_byte)
                  SC_LSHIFT: shift_l_next = 1'b1;
                  SC_RSHIFT: shift_r_next = 1'b1;
                  SC_CAPS:   caps_next    = !caps;
                  SC_BREAK, SC_EXT: ;
                  default: begin
                     push_next      = (lookup != ASCII_NONE);
                     push_char_next = lookup;
                  end
               endcase
            end
            ST_BRK: begin
               if (rx_byte == SC_LSHIFT) shift_l_next = 1'b0;
               if (rx_byte == SC_RSHIFT) shift_r_next = 1'b0;
            end
            ST_EXT: begin
               if (rx_byte == SC_ENTER) begin
                  push_next      = 1'b1;
                  push_char_next = ASCII_LF;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         shift_l   <= 1'b0;
         shift_r   <= 1'b0;
         caps      <= 1'b0;
         push_req  <= 1'b0;
         push_char <= ASCII_NONE;
      end else begin
         shift_l   <= shift_l_next;
         shift_r   <= shift_r_next;
         caps      <= caps_next;
         push_req  <= push_next;
         push_char <= push_char_next;
      end
   end

   // ---------------- character FIFO ----------------
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt;
   logic          is_empty, full;
   logic          do_pop, do_push, push_drop;
   logic          overflow, frame_err;

   assign is_empty  = (cnt == '0);
   assign full      = (cnt == CW'(DEPTH));
   assign do_pop    = bus.rd_en && !is_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign do_push   = push_req && (!full || do_pop);
   assign push_drop = push_req && full && !do_pop;

   // NOTE: storage is deliberately not reset; stale entries are never visible because empty masks the head.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_char;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
         // A new error in the same cycle as clr_err keeps the flag set.
         if      (push_drop)   overflow <= 1'b1;
         else if (bus.clr_err) overflow <= 1'b0;
         if      (frame_bad)   frame_err <= 1'b1;
         else if (bus.clr_err) frame_err <= 1'b0;
      end
   end

   assign bus.ascii_key = is_empty ? ASCII_NONE : mem[rd_ptr];
   assign bus.empty     = is_empty;
   assign bus.count     = cnt;
   assign bus.overflow  = overflow;
   assign bus.frame_err = frame_err;

endmodule

// File: tb/tb_kbd_fifo.sv
// Self-checking bench for kbd_fifo: directed scenarios plus randomized keystrokes
// compared against a queue-based keyboard model.
`timescale 1ns/1ps
module tb_kbd_fifo;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clock    = 1'b0;
   logic reset    = 1'b0;
   logic ps2_clk  = 1'b1;
   logic ps2_data = 1'b1;

   kbd_fifo_if #(.DEPTH(DEPTH)) bus ();

   kbd_fifo #(.DEPTH(DEPTH), .TIMEOUT(5000)) dut (
      .clock    (clock),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .bus      (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   logic [CW-1:0] pre_count;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // ---------------- reference model ----------------
   string      letters_lo = "abcdefghijklmnopqrstuvwxyz";
   string      letters_up = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
   logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] sym_plain [21]   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h30,
                                    8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
   logic [7:0] sym_shifted [21] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28, 8'h29,
                                    8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
   logic [7:0] sym_sc [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
                               8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};

   logic [7:0] q [$];
   logic m_ovf, m_ferr, m_shl, m_shr, m_caps, m_brk, m_ext;

   function automatic logic [7:0] ref_ascii(input logic [7:0] sc, input logic shifted, input logic caps_on);
      for (int i = 0; i < 26; i++)
         if (letter_sc[i] == sc) return (shifted ^ caps_on) ? letters_up[i] : letters_lo[i];
      for (int i = 0; i < 21; i++)
         if (sym_sc[i] == sc) return shifted ? sym_shifted[i] : sym_plain[i];
      case (sc)
         8'h5A:   return 8'h0A;
         8'h66:   return 8'h08;
         8'h29:   return 8'h20;
         8'h76:   return 8'h1B;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      q.delete();
      {m_ovf, m_ferr, m_shl, m_shr, m_caps, m_brk, m_ext} = '0;
   endtask

   task automatic model_push(input logic [7:0] c);
      if (q.size() < DEPTH) q.push_back(c);
      else                  m_ovf = 1'b1;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] c;
      if (m_ext && m_brk) begin
         m_ext = 1'b0; m_brk = 1'b0;
      end else if (m_ext) begin
         if (b == 8'hF0) m_brk = 1'b1;
         else begin
            if (b == 8'h5A) model_push(8'h0A);
            m_ext = 1'b0;
         end
      end else if (m_brk) begin
         if (b == 8'h12) m_shl = 1'b0;
         if (b == 8'h59) m_shr = 1'b0;
         m_brk = 1'b0;
      end else if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'h12) m_shl = 1'b1;
      else if (b == 8'h59) m_shr = 1'b1;
      else if (b == 8'h58) m_caps = !m_caps;
      else begin
         c = ref_ascii(b, m_shl | m_shr, m_caps);
         if (c != 8'h00) model_push(c);
      end
   endtask

   // ---------------- stimulus ----------------
   // One PS/2 bit; on the last bit of a frame rd_en can be pulsed in the push cycle.
   task automatic ps2_bit(input logic b, input logic pop_at_push);
      @(negedge clock);
      ps2_data = b;
      repeat (3) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (4) @(negedge clock);
      pre_count = bus.count;
      if (pop_at_push) bus.rd_en = 1'b1;
      @(negedge clock);
      bus.rd_en = 1'b0;
      ps2_clk   = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic pop_at_push);
      logic [10:0] f;
      f = {1'b1, ~(^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < 11; i++) ps2_bit(f[i], pop_at_push && (i == 10));
   endtask

   task automatic key(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0);
      model_byte(b);
   endtask

   task automatic pop_one();
      @(negedge clock);
      bus.rd_en = 1'b1;
      @(negedge clock);
      bus.rd_en = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
   endtask

   task automatic clear_errors();
      @(negedge clock);
      bus.clr_err = 1'b1;
      @(negedge clock);
      bus.clr_err = 1'b0;
      m_ovf  = 1'b0;
      m_ferr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic compare_model(input string tag);
      check({tag, ":count"}, 32'(bus.count), q.size());
      check({tag, ":head"},  32'(bus.ascii_key), (q.size() > 0) ? 32'(q[0]) : 32'h0);
      check({tag, ":empty"}, 32'(bus.empty), 32'(q.size() == 0));
      check({tag, ":ovf"},   32'(bus.overflow), 32'(m_ovf));
      check({tag, ":ferr"},  32'(bus.frame_err), 32'(m_ferr));
   endtask

   logic [7:0] pool [28] = '{8'h1C, 8'h32, 8'h21, 8'h15, 8'h1A, 8'h16, 8'h45, 8'h46, 8'h0E, 8'h4E,
                             8'h5D, 8'h52, 8'h4A, 8'h41, 8'h12, 8'h59, 8'h58, 8'hF0, 8'hF0, 8'hE0,
                             8'h5A, 8'h66, 8'h29, 8'h76, 8'h05, 8'h07, 8'h00, 8'hFF};

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      bus.rd_en   = 1'b0;
      bus.clr_err = 1'b0;
      model_reset();

      // Reset state
      repeat (3) @(negedge clock);
      check("rst:count", 32'(bus.count), 0);
      check("rst:empty", 32'(bus.empty), 1);
      check("rst:head",  32'(bus.ascii_key), 0);
      check("rst:ovf",   32'(bus.overflow), 0);
      check("rst:ferr",  32'(bus.frame_err), 0);
      reset = 1'b1;

      // 1C then F0 1C: one 'a'; count still 0 one cycle before the push lands
      send_frame(8'h1C, 1'b0, 1'b0);
      check("lat:pre_count", 32'(pre_count), 0);
      check("lat:count", 32'(bus.count), 1);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      check("a:head",  32'(bus.ascii_key), 32'h61);
      check("a:count", 32'(bus.count), 1);
      pop_one();
      check("a:pop_head",  32'(bus.ascii_key), 0);
      check("a:pop_empty", 32'(bus.empty), 1);

      // Shift, caps lock and their interaction
      do_reset();
      foreach (pool[i]) if (i < 0) key(8'h00);
      key(8'h12); key(8'h1C); key(8'hF0); key(8'h1C); key(8'hF0); key(8'h12);
      check("shift:head", 32'(bus.ascii_key), 32'h41);
      key(8'h58); key(8'h1C);
      key(8'h12); key(8'h1C);
      key(8'h16);
      key(8'hF0); key(8'h12);
      key(8'h16);
      check("case:count", 32'(bus.count), 5);
      check("case:e0", 32'(bus.ascii_key), 32'h41);
      pop_one(); check("case:e1", 32'(bus.ascii_key), 32'h41);
      pop_one(); check("case:e2", 32'(bus.ascii_key), 32'h61);
      pop_one(); check("case:e3", 32'(bus.ascii_key), 32'h21);
      pop_one(); check("case:e4", 32'(bus.ascii_key), 32'h31);
      pop_one();

      // Extended Enter, extended break ignored
      key(8'hE0); key(8'h5A); key(8'hE0); key(8'hF0); key(8'h5A);
      check("ext:count", 32'(bus.count), 1);
      check("ext:head",  32'(bus.ascii_key), 32'h0A);
      pop_one();

      // Bad parity
      send_frame(8'h1C, 1'b1, 1'b0);
      check("par:count", 32'(bus.count), 0);
      check("par:ferr",  32'(bus.frame_err), 1);
      clear_errors();
      check("par:clr",   32'(bus.frame_err), 0);

      // Overflow on the ninth push
      do_reset();
      key(8'h16); key(8'h1E); key(8'h26); key(8'h25); key(8'h2E);
      key(8'h36); key(8'h3D); key(8'h3E); key(8'h46);
      check("ovf:count", 32'(bus.count), 8);
      check("ovf:flag",  32'(bus.overflow), 1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("ovf:pop%0d", i), 32'(bus.ascii_key), 32'h31 + i);
         pop_one();
      end
      check("ovf:drained", 32'(bus.empty), 1);

      // Full FIFO with push and pop in the same cycle
      clear_errors();
      send_frame(8'h16, 1'b0, 1'b0); send_frame(8'h1E, 1'b0, 1'b0);
      send_frame(8'h26, 1'b0, 1'b0); send_frame(8'h25, 1'b0, 1'b0);
      send_frame(8'h2E, 1'b0, 1'b0); send_frame(8'h36, 1'b0, 1'b0);
      send_frame(8'h3D, 1'b0, 1'b0); send_frame(8'h3E, 1'b0, 1'b0);
      send_frame(8'h46, 1'b0, 1'b1);
      check("pp:count", 32'(bus.count), 8);
      check("pp:head",  32'(bus.ascii_key), 32'h32);
      check("pp:ovf",   32'(bus.overflow), 0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("pp:pop%0d", i), 32'(bus.ascii_key), 32'h32 + i);
         pop_one();
      end

      // Partial frame discarded by reset
      ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0); ps2_bit(1'b0, 1'b0);
      ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0);
      do_reset();
      send_frame(8'h29, 1'b0, 1'b0);
      check("rstmid:count", 32'(bus.count), 1);
      check("rstmid:head",  32'(bus.ascii_key), 32'h20);
      check("rstmid:ferr",  32'(bus.frame_err), 0);
      pop_one();

      // Partial frame discarded by timeout
      ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0); ps2_bit(1'b0, 1'b0);
      ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0);
      repeat (5100) @(negedge clock);
      send_frame(8'h29, 1'b0, 1'b0);
      check("tmo:count", 32'(bus.count), 1);
      check("tmo:head",  32'(bus.ascii_key), 32'h20);
      check("tmo:ferr",  32'(bus.frame_err), 0);

      // Randomized keystrokes against the model
      do_reset();
      for (int k = 0; k < 200; k++) begin
         r = $urandom_range(0, 99);
         if (r < 30) pop_one();
         else if (r < 34) clear_errors();
         else if (r < 38) begin
            send_frame(8'($urandom), 1'b1, 1'b0);
            m_ferr = 1'b1;
         end else key(pool[$urandom_range(0, 27)]);
         compare_model($sformatf("rnd%0d", k));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/kbd_fifo.md
Name: kbd_fifo

Overview:
- PS/2 keyboard front end that feeds the memory-mapped KBD_ASCII read port of the SoC.
- Receives raw PS/2 frames and tracks make/break/extended prefixes and Shift/CapsLock state.
- Translates make codes to ASCII and queues them in a FIFO.
- The CPU consumes one character per read strobe, so no keystroke is lost between polls.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- TIMEOUT, 5000, clock cycles without a ps2_clk falling edge before a partial frame is discarded.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock (asynchronous).
- ps2_data  in  1  raw PS/2 data (asynchronous).
- rd_en  in  1  single-cycle pop strobe from the CPU read decode.
- ascii_key  out  8  FIFO head; 8'h00 when empty.
- empty  out  1  FIFO empty.
- count  out  $clog2(DEPTH)+1  number of stored entries.
- overflow  out  1  sticky: a push was dropped because the FIFO was full.
- frame_err  out  1  sticky: a frame with bad start, stop or parity was received.
- clr_err  in  1  clears overflow and frame_err.

Behaviour:
- Reset (reset==0 at posedge): all state cleared.
  - FIFO empty, count=0, ascii_key=0, empty=1, overflow=0, frame_err=0.
  - Bit counter 0, decode FSM in IDLE, shift_l=shift_r=caps=0.
  - Reset in the middle of a frame discards the partial frame.
- Synchroniser: ps2_clk and ps2_data each pass through 3 flops. A falling edge is registered when sync[2:1]==2'b10.
- Receiver:
  - 11 bits are sampled on falling edges: start, d0..d7 (LSB first), odd parity, stop.
  - After the 11th bit the frame is valid iff start==0, stop==1 and ^{d,parity}==1.
  - A valid frame produces byte_valid for 1 cycle.
  - An invalid frame is dropped and sets frame_err.
  - Timeout counter: reset on every falling edge. If it reaches TIMEOUT while the bit counter is nonzero, the bit counter returns to 0. No error flag is set on timeout.
- Decode FSM, states IDLE, BRK, EXT, EXT_BRK:
  - IDLE:
    - F0 -> BRK.
    - E0 -> EXT.
    - 12 -> shift_l=1.
    - 59 -> shift_r=1.
    - 58 -> toggle caps.
    - Any other code -> lookup; push if the result is nonzero.
  - BRK:
    - 12 -> shift_l=0.
    - 59 -> shift_r=0.
    - Any other code -> no action.
    - Always returns to IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - 5A -> push 8'h0A.
    - Any other code -> no push, return to IDLE.
  - EXT_BRK: any byte returns to IDLE with no action.
  - Typematic repeat make codes push again.
- Translation:
  - Letters are upper case iff (shift_l|shift_r) XOR caps.
  - Digits and punctuation use the shifted glyph iff shift_l|shift_r.
  - Enter 5A -> 0x0A, Backspace 66 -> 0x08, Space 29 -> 0x20, Esc 76 -> 0x1B.
  - Unmapped codes -> 0, which means no push.
- Latency:
  - Let cycle N be the cycle in which the 11th falling edge is registered.
  - byte_valid is asserted in N+1; the push happens at the end of N+2.
  - ascii_key, empty and count update from cycle N+3.
- FIFO:
  - ascii_key = empty ? 0 : mem[rd_ptr], combinational from registers.
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally.
  - Pop (rd_en) when empty is ignored.
  - Push when full is dropped, sets overflow, and leaves contents unchanged.
  - Push and pop in the same cycle:
    - Not empty (including full): both happen, count unchanged, head advances.
    - Empty: push only.
  - clr_err in the same cycle as a new error: the error wins and the flag stays set.

Decomposition:
- kbd_pkg holds:
  - scancode constants: SC_BREAK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58, SC_ENTER=5A;
  - the decode-state enum;
  - ASCII_NONE=8'h00.
- Sub-module scancode_to_ascii: purely combinational table; inputs scancode[7:0], shift, caps; output ascii[7:0].
- The receiver, decode FSM and FIFO stay in kbd_fifo.

Test Plan:
- Frame 1C then F0 1C -> one push; ascii_key=0x61, count=1. rd_en pulse -> ascii_key=0x00, empty=1.
- Frames 12, 1C, F0 1C, F0 12 -> ascii_key=0x41. Then 58, 1C -> second entry 0x41; with 12 held and caps=1 -> 0x61.
- Frame 1C with parity bit flipped -> no push, frame_err=1. clr_err -> frame_err=0.
- 9 make codes 16,1E,26,25,2E,36,3D,3E,46 with no pops:
  - count=8, overflow=1;
  - popping 8 times yields 0x31..0x38.
- FIFO full plus push and rd_en in the same cycle -> count stays 8, head becomes the second entry, overflow unchanged.
- 5 bits of a frame, then reset low for 1 cycle (or 5000 idle cycles), then a complete 29 frame -> exactly one push of 0x20, frame_err=0.
